mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial memory controller: the responder side of the cache-to-memory protocol. It accepts word/half/byte load and store requests from the data cache and 4-byte fetch requests from the instruction cache. It arbitrates between them and sequences each request as individual byte accesses on the 8-bit RAM/IO bus. It returns a one-cycle done pulse with assembled data and exposes a per-port busy (`wait`) vector back to the requesters.

## Interface
- `IO_BASE`, default 32'h0003_0000: addresses >= this are IO; stores there honor `io_buffer_full`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; 0 = stall.
- `io_buffer_full` in 1: IO write buffer full.
- `mem_din` in 8: RAM read byte, valid the cycle after its address.
- `mem_dout` out 8: RAM write byte.
- `mem_a` out 32: RAM byte address.
- `mem_wr` out 1: 1 = write, 0 = read.
- `iDC_en` in 1: data request valid.
- `iDC_ls` in 1: 1 = store, 0 = load.
- `iDC_pc` in 32: data byte address.
- `iDC_dt` in 32: store data, little-endian.
- `iDC_len` in 3: access length in bytes; legal values 1, 2, 4.
- `oDC_done` out 1: data request complete (pulse).
- `oDC_dt` out 32: load data, zero-extended.
- `iIC_en` in 1: fetch request valid.
- `iIC_pc` in 32: fetch address.
- `oIC_done` out 1: fetch complete (pulse).
- `oIC_dt` out 32: fetched word.
- `oMC_wait` out 2: bit1 = data port busy; bit0 = fetch port busy.

## Operation
- Reset values: `mem_a`=0, `mem_dout`=0, `mem_wr`=0, `oDC_done`=0, `oIC_done`=0, `oDC_dt`=0, `oIC_dt`=0, `oMC_wait`=2'b00. State is IDLE.
- States:
  - IDLE: accept a request, or stay.
  - READ: issue and capture bytes.
  - WRITE: emit bytes.
  - DONE: pulse done, then return to IDLE.
- Acceptance happens only in IDLE with `rdy`=1.
  - `iDC_en`=1 wins over `iIC_en`=1 when both are asserted.
  - Winner's address, data, length and port are latched. An instruction fetch latches length 4 and load.
  - Both `oMC_wait` bits go to 1 from the cycle after acceptance through the DONE cycle inclusive. They return to 0 in the following IDLE cycle.
  - `en` is ignored whenever the port's wait bit is 1.
- Address of byte i = latched address + i, modulo 2^32.
- READ state:
  - Byte i's address is driven on `mem_a` with `mem_wr`=0.
  - The byte arriving on `mem_din` next cycle is placed at bits [8i+7:8i]. Issue is pipelined: one address per cycle.
  - Capture rule: a byte is captured only if its address was driven in the immediately preceding cycle with `rdy`=1.
  - After a stall, the issue index rewinds to the capture index, so no byte is lost or duplicated in the result.
  - Exit to DONE after byte len-1 is captured.
- WRITE state:
  - Byte i drives `mem_a` = addr+i, `mem_dout` = `iDC_dt`[8i+7:8i], `mem_wr`=1.
  - If `io_buffer_full`=1 and addr+i >= `IO_BASE`: drive `mem_wr`=0, hold i, and retry next cycle.
  - Exit to DONE after byte len-1 is written.
- DONE state:
  - Asserts exactly one of `oDC_done`/`oIC_done` for 1 cycle, with `oDC_dt`/`oIC_dt` valid in the same cycle.
  - Load data bits above len×8 are 0. For stores, `oDC_dt`=0.
  - Data outputs hold until the next done on that port.
- `rdy`=0:
  - All registers hold.
  - `mem_wr` is forced to 0 combinationally.
  - Done pulses are not issued until `rdy` returns; a stalled DONE simply extends.
- `rst` mid-request: the request is dropped with no done. All outputs take reset values next cycle. The requester must re-issue.
- Illegal `iDC_len` (0, 3, 5–7) is treated as 4.

## Timing
- Request sampled at the edge ending cycle 0.
- Read of n bytes:
  - Addresses in cycles 1..n.
  - Captures at the edges ending cycles 2..n+1.
  - Done in cycle n+2.
  - 4-byte load/fetch: done in cycle 6.
- Write of n bytes: writes in cycles 1..n, done in cycle n+1, plus one cycle per `io_buffer_full` retry.
- Back-to-back: the next request can be accepted in the IDLE cycle after DONE. Minimum spacing is n+3 cycles for reads and n+2 for writes.
- Fetch-port starvation is possible under continuous data traffic; this is by design (data priority).

## Test plan
- Word load: RAM[0x100..0x103] = 11,22,33,44 hex; `iDC_en`, `ls`=0, pc 0x100, len 4. Required: `mem_a` 0x100..0x103 in cycles 1–4; `oDC_done` in cycle 6 with `oDC_dt`=0x44332211; `oMC_wait`=2'b11 during cycles 1–6.
- Half store: pc 0x202, dt 0xDEADBEEF, len 2. Required: `mem_wr`=1 with (0x202, 0xEF), (0x203, 0xBE) in cycles 1–2; done in cycle 3; `oDC_dt`=0.
- Simultaneous requests: `iDC_en` load of byte 0x10 (value 0x80) and `iIC_en` fetch of 0x0. Required: data served first with `oDC_dt`=0x00000080; fetch accepted after; `oIC_done` with the correct word.
- IO store with `io_buffer_full`: store byte 0x41 to 0x30000 with `io_buffer_full`=1 for 3 cycles. Required: `mem_wr`=0 during those cycles; a single write in the cycle `io_buffer_full` falls; done the next cycle.
- Stall mid-read: 4-byte fetch at 0x0; `rdy`=0 in cycles 3–4. Required: `mem_wr`=0; the assembled word is correct and identical to the unstalled result; done delayed accordingly.
- Reset mid-store: `rst` in cycle 2 of a 4-byte store. Required: no done pulse; all outputs at reset values next cycle; only bytes 0–1 written.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl -- byte-serial memory controller (responder side of the
// cache-to-memory protocol).
//
// Takes word/half/byte loads and stores from the data cache and 4-byte
// fetches from the instruction cache. When both ask in the same cycle, the
// data cache wins. Each request is turned into single-byte accesses on an
// 8-bit RAM/IO bus. A one-cycle done pulse returns the assembled data.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   rdy               global enable (0 = stall, all state holds)
//   io_buffer_full    IO write buffer full; stores at or above IO_BASE wait
//   mem_din           RAM read byte, valid the cycle after its address
//   mem_dout/mem_a    RAM write byte / byte address
//   mem_wr            1 = write, 0 = read
//   iDC_*             data request: en, ls (1 = store), pc, dt, len (1/2/4)
//   oDC_done/oDC_dt   data request completion pulse / load data (zero-ext.)
//   iIC_en/iIC_pc     instruction fetch request
//   oIC_done/oIC_dt   fetch completion pulse / fetched word
//   oMC_wait          {data busy, fetch busy}
module mem_ctrl #(
   parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        io_buffer_full,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        iDC_en,
   input  logic        iDC_ls,
   input  logic [31:0] iDC_pc,
   input  logic [31:0] iDC_dt,
   input  logic [2:0]  iDC_len,
   output logic        oDC_done,
   output logic [31:0] oDC_dt,
   input  logic        iIC_en,
   input  logic [31:0] iIC_pc,
   output logic        oIC_done,
   output logic [31:0] oIC_dt,
   output logic [1:0]  oMC_wait
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;     // store data, or load bytes gathered so far
   logic [2:0]  len_q, len_d;       // always 1, 2 or 4
   logic        dc_q, dc_d;         // 1 = current request came from the data port
   logic [2:0]  issue_q, issue_d;   // next byte index to address (read) / write
   logic [2:0]  cap_q, cap_d;       // next byte index to capture (read)
   logic        pend_q, pend_d;     // an address was driven last cycle with rdy=1
   logic [31:0] dc_dt_q, dc_dt_d;
   logic [31:0] ic_dt_q, ic_dt_d;

   logic [2:0]  dc_len;
   logic [2:0]  cur_idx;
   logic [2:0]  last_idx;
   logic [31:0] byte_addr;
   logic        io_blocked;
   logic [31:0] cap_word;

   // Anything other than 1 or 2 is treated as a full word.
   always_comb begin
      case (iDC_len)
         3'd1:    dc_len = 3'd1;
         3'd2:    dc_len = 3'd2;
         default: dc_len = 3'd4;
      endcase
   end

   // When no address went out with rdy=1 last cycle (first READ cycle or
   // just after a stall), nothing is in flight: reissue from the capture
   // index so that no byte is lost or duplicated.
   assign cur_idx    = (state_q == S_READ && !pend_q) ? cap_q : issue_q;
   assign last_idx   = len_q - 3'd1;
   assign byte_addr  = addr_q + {29'd0, cur_idx};
   assign io_blocked = io_buffer_full && (byte_addr >= IO_BASE);

   always_comb begin
      cap_word = data_q;
      cap_word[{cap_q[1:0], 3'b000} +: 8] = mem_din;
   end

   assign mem_a    = (state_q == S_READ || state_q == S_WRITE) ? byte_addr : 32'd0;
   assign mem_dout = (state_q == S_WRITE) ? data_q[{cur_idx[1:0], 3'b000} +: 8] : 8'd0;
   assign mem_wr   = (state_q == S_WRITE) && rdy && !io_blocked;
   assign oDC_done = (state_q == S_DONE) && rdy && dc_q;
   assign oIC_done = (state_q == S_DONE) && rdy && !dc_q;
   assign oMC_wait = {2{state_q != S_IDLE}};
   assign oDC_dt   = dc_dt_q;
   assign oIC_dt   = ic_dt_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      len_d   = len_q;
      dc_d    = dc_q;
      issue_d = issue_q;
      cap_d   = cap_q;
      pend_d  = 1'b0;
      dc_dt_d = dc_dt_q;
      ic_dt_d = ic_dt_q;

      if (rdy) begin
         case (state_q)
            S_IDLE: begin
               issue_d = 3'd0;
               cap_d   = 3'd0;
               if (iDC_en) begin
                  addr_d  = iDC_pc;
                  dc_d    = 1'b1;
                  len_d   = dc_len;
                  data_d  = iDC_ls ? iDC_dt : 32'd0;
                  state_d = iDC_ls ? S_WRITE : S_READ;
               end else if (iIC_en) begin
                  addr_d  = iIC_pc;
                  dc_d    = 1'b0;
                  len_d   = 3'd4;
                  data_d  = 32'd0;
                  state_d = S_READ;
               end
            end
            S_READ: begin
               if (pend_q) begin
                  data_d = cap_word;
                  cap_d  = cap_q + 3'd1;
                  if (cap_q == last_idx) begin
                     state_d = S_DONE;
                     if (dc_q) dc_dt_d = cap_word;
                     else      ic_dt_d = cap_word;
                  end
               end
               if (cur_idx < len_q) begin
                  issue_d = cur_idx + 3'd1;
                  pend_d  = 1'b1;
               end
            end
            S_WRITE: begin
               if (!io_blocked) begin
                  if (issue_q == last_idx) begin
                     state_d = S_DONE;
                     dc_dt_d = 32'd0;
                  end else begin
                     issue_d = issue_q + 3'd1;
                  end
               end
            end
            default: state_d = S_IDLE;   // S_DONE: pulse issued this cycle
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= 32'd0;
         data_q  <= 32'd0;
         len_q   <= 3'd4;
         dc_q    <= 1'b0;
         issue_q <= 3'd0;
         cap_q   <= 3'd0;
         pend_q  <= 1'b0;
         dc_dt_q <= 32'd0;
         ic_dt_q <= 32'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         len_q   <= len_d;
         dc_q    <= dc_d;
         issue_q <= issue_d;
         cap_q   <= cap_d;
         pend_q  <= pend_d;
         dc_dt_q <= dc_dt_d;
         ic_dt_q <= ic_dt_d;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl -- directed bench for mem_ctrl. A small byte RAM model answers
// reads one cycle after the address and logs every write. Each transaction
// records a per-cycle trace (cycle 0 = request presented); expected values
// are hand-computed constants.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst, rdy, io_buffer_full;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        iDC_en, iDC_ls;
   logic [31:0] iDC_pc, iDC_dt;
   logic [2:0]  iDC_len;
   logic        oDC_done;
   logic [31:0] oDC_dt;
   logic        iIC_en;
   logic [31:0] iIC_pc;
   logic        oIC_done;
   logic [31:0] oIC_dt;
   logic [1:0]  oMC_wait;

   always #5 clk = ~clk;

   mem_ctrl #(.IO_BASE(32'h0003_0000)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .iDC_en(iDC_en), .iDC_ls(iDC_ls), .iDC_pc(iDC_pc), .iDC_dt(iDC_dt),
      .iDC_len(iDC_len), .oDC_done(oDC_done), .oDC_dt(oDC_dt),
      .iIC_en(iIC_en), .iIC_pc(iIC_pc), .oIC_done(oIC_done), .oIC_dt(oIC_dt),
      .oMC_wait(oMC_wait)
   );

   // RAM model: low 4 KiB backed, everything else (IO) only logged.
   logic [7:0]  ram [0:4095];
   logic [31:0] wlog_a[$];
   logic [7:0]  wlog_d[$];

   always @(posedge clk) begin
      mem_din <= ram[mem_a[11:0]];
      if (mem_wr) begin
         wlog_a.push_back(mem_a);
         wlog_d.push_back(mem_dout);
         if (mem_a < 32'h1000) ram[mem_a[11:0]] <= mem_dout;
      end
   end

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Request fields held for a transaction.
   logic        req_ls;
   logic [31:0] req_pc, req_dt, req_ic_pc;
   logic [2:0]  req_len;

   // Per-cycle trace.
   logic [31:0] tr_a   [0:31];
   logic        tr_wr  [0:31];
   logic [7:0]  tr_do  [0:31];
   logic        tr_dd  [0:31];
   logic        tr_id  [0:31];
   logic [31:0] tr_ddt [0:31];
   logic [31:0] tr_idt [0:31];
   logic [1:0]  tr_w   [0:31];
   int          tr_n;

   // Masks give the value of each stimulus bit in cycle k (bit k).
   task automatic run_txn(input int ncyc, input logic [31:0] dc_m, input logic [31:0] ic_m,
                          input logic [31:0] rdy_low, input logic [31:0] iof_hi,
                          input logic [31:0] rst_hi);
      wlog_a.delete();
      wlog_d.delete();
      tr_n = ncyc;
      for (int k = 0; k < ncyc; k++) begin
         @(posedge clk);
         #1;
         iDC_en = dc_m[k];  iDC_ls = req_ls; iDC_pc = req_pc;
         iDC_dt = req_dt;   iDC_len = req_len;
         iIC_en = ic_m[k];  iIC_pc = req_ic_pc;
         rdy = !rdy_low[k]; io_buffer_full = iof_hi[k]; rst = rst_hi[k];
         @(negedge clk);
         tr_a[k] = mem_a;    tr_wr[k] = mem_wr;    tr_do[k] = mem_dout;
         tr_dd[k] = oDC_done; tr_id[k] = oIC_done;
         tr_ddt[k] = oDC_dt; tr_idt[k] = oIC_dt;   tr_w[k] = oMC_wait;
      end
      iDC_en = 1'b0; iIC_en = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0; rst = 1'b0;
   endtask

   function automatic int cnt_dd();
      int c = 0;
      for (int k = 0; k < tr_n; k++) if (tr_dd[k]) c++;
      return c;
   endfunction

   function automatic int cnt_id();
      int c = 0;
      for (int k = 0; k < tr_n; k++) if (tr_id[k]) c++;
      return c;
   endfunction

   function automatic int cnt_wr();
      int c = 0;
      for (int k = 0; k < tr_n; k++) if (tr_wr[k]) c++;
      return c;
   endfunction

   initial begin
      for (int i = 0; i < 4096; i++) ram[i] = 8'h5A ^ i[7:0];
      ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
      ram[12'h010] = 8'h80;
      ram[12'h000] = 8'h93; ram[12'h001] = 8'h00; ram[12'h002] = 8'h10; ram[12'h003] = 8'h00;

      rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
      iDC_en = 1'b0; iDC_ls = 1'b0; iDC_pc = '0; iDC_dt = '0; iDC_len = 3'd4;
      iIC_en = 1'b0; iIC_pc = '0;
      req_ls = 1'b0; req_pc = '0; req_dt = '0; req_len = 3'd4; req_ic_pc = '0;

      // Reset state
      run_txn(3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3);
      check_val("rst_mem_a",  tr_a[2], 32'h0);
      check_val("rst_mem_dout", 32'(tr_do[2]), 32'h0);
      check_val("rst_mem_wr", 32'(tr_wr[2]), 32'h0);
      check_val("rst_dones",  {30'd0, tr_dd[2], tr_id[2]}, 32'h0);
      check_val("rst_dc_dt",  tr_ddt[2], 32'h0);
      check_val("rst_ic_dt",  tr_idt[2], 32'h0);
      check_val("rst_wait",   32'(tr_w[2]), 32'h0);
      $display("txn reset: outputs sampled");

      // Word load at 0x100
      req_ls = 1'b0; req_pc = 32'h100; req_len = 3'd4;
      run_txn(8, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         check_val("t1_addr", tr_a[k], 32'h100 + 32'(k - 1));
         check_val("t1_wr", 32'(tr_wr[k]), 32'h0);
      end
      check_val("t1_wait_c0", 32'(tr_w[0]), 32'h0);
      for (int k = 1; k <= 6; k++) check_val("t1_wait_busy", 32'(tr_w[k]), 32'h3);
      check_val("t1_wait_c7", 32'(tr_w[7]), 32'h0);
      check_val("t1_done_c6", 32'(tr_dd[6]), 32'h1);
      check_val("t1_done_cnt", 32'(cnt_dd()), 32'h1);
      check_val("t1_ic_done_cnt", 32'(cnt_id()), 32'h0);
      check_val("t1_data", tr_ddt[6], 32'h4433_2211);
      $display("txn word load 0x100: oDC_dt=0x%08h", tr_ddt[6]);

      // Half store at 0x202
      req_ls = 1'b1; req_pc = 32'h202; req_dt = 32'hDEAD_BEEF; req_len = 3'd2;
      run_txn(5, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0);
      check_val("t2_wr_c1", 32'(tr_wr[1]), 32'h1);
      check_val("t2_a_c1", tr_a[1], 32'h202);
      check_val("t2_do_c1", 32'(tr_do[1]), 32'hEF);
      check_val("t2_wr_c2", 32'(tr_wr[2]), 32'h1);
      check_val("t2_a_c2", tr_a[2], 32'h203);
      check_val("t2_do_c2", 32'(tr_do[2]), 32'hBE);
      check_val("t2_wr_c3", 32'(tr_wr[3]), 32'h0);
      check_val("t2_done_c3", 32'(tr_dd[3]), 32'h1);
      check_val("t2_dt_zero", tr_ddt[3], 32'h0);
      check_val("t2_nwrites", 32'(wlog_a.size()), 32'h2);
      $display("txn half store 0x202: %0d bytes written", wlog_a.size());

      // Simultaneous data byte load and fetch; fetch held until served
      req_ls = 1'b0; req_pc = 32'h10; req_len = 3'd1; req_ic_pc = 32'h0;
      run_txn(12, 32'h1, 32'h1F, 32'h0, 32'h0, 32'h0);
      check_val("t3_dc_addr", tr_a[1], 32'h10);
      check_val("t3_dc_done_c3", 32'(tr_dd[3]), 32'h1);
      check_val("t3_dc_data", tr_ddt[3], 32'h0000_0080);
      check_val("t3_idle_c4", 32'(tr_w[4]), 32'h0);
      check_val("t3_ic_a_c5", tr_a[5], 32'h0);
      check_val("t3_ic_a_c8", tr_a[8], 32'h3);
      check_val("t3_ic_done_c10", 32'(tr_id[10]), 32'h1);
      check_val("t3_ic_data", tr_idt[10], 32'h0010_0093);
      check_val("t3_dc_cnt", 32'(cnt_dd()), 32'h1);
      check_val("t3_ic_cnt", 32'(cnt_id()), 32'h1);
      check_val("t3_dc_hold", tr_ddt[10], 32'h0000_0080);
      $display("txn dc+ic: oDC_dt=0x%08h oIC_dt=0x%08h", tr_ddt[3], tr_idt[10]);

      // IO store with io_buffer_full for cycles 1-3
      req_ls = 1'b1; req_pc = 32'h0003_0000; req_dt = 32'h41; req_len = 3'd1;
      run_txn(7, 32'h1, 32'h0, 32'h0, 32'hE, 32'h0);
      for (int k = 1; k <= 3; k++) check_val("t4_blocked_wr", 32'(tr_wr[k]), 32'h0);
      check_val("t4_wr_c4", 32'(tr_wr[4]), 32'h1);
      check_val("t4_a_c4", tr_a[4], 32'h0003_0000);
      check_val("t4_do_c4", 32'(tr_do[4]), 32'h41);
      check_val("t4_done_c5", 32'(tr_dd[5]), 32'h1);
      check_val("t4_done_cnt", 32'(cnt_dd()), 32'h1);
      check_val("t4_nwrites", 32'(wlog_a.size()), 32'h1);
      $display("txn io store 0x30000: %0d writes", wlog_a.size());

      // Fetch at 0 with rdy low in cycles 3-4
      req_ic_pc = 32'h0;
      run_txn(12, 32'h0, 32'h1, 32'h18, 32'h0, 32'h0);
      check_val("t5_no_wr", 32'(cnt_wr()), 32'h0);
      check_val("t5_rewind_a_c5", tr_a[5], 32'h1);
      check_val("t5_ic_cnt", 32'(cnt_id()), 32'h1);
      check_val("t5_done_c9", 32'(tr_id[9]), 32'h1);
      check_val("t5_data", tr_idt[9], 32'h0010_0093);
      check_val("t5_dc_cnt", 32'(cnt_dd()), 32'h0);
      $display("txn stalled fetch 0x0: oIC_dt=0x%08h", tr_idt[9]);

      // Illegal length 3 behaves as a word load
      req_ls = 1'b0; req_pc = 32'h100; req_len = 3'd3;
      run_txn(8, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0);
      check_val("t6_a_c4", tr_a[4], 32'h103);
      check_val("t6_done_c6", 32'(tr_dd[6]), 32'h1);
      check_val("t6_data", tr_ddt[6], 32'h4433_2211);
      $display("txn len3 load 0x100: oDC_dt=0x%08h", tr_ddt[6]);

      // Half load at 0x102: upper bytes zero, done in cycle 4
      req_ls = 1'b0; req_pc = 32'h102; req_len = 3'd2;
      run_txn(6, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0);
      check_val("t7_done_c4", 32'(tr_dd[4]), 32'h1);
      check_val("t7_data", tr_ddt[4], 32'h0000_4433);
      $display("txn half load 0x102: oDC_dt=0x%08h", tr_ddt[4]);

      // Reset during cycle 2 of a word store
      req_ls = 1'b1; req_pc = 32'h300; req_dt = 32'h0A0B_0C0D; req_len = 3'd4;
      run_txn(8, 32'h1, 32'h0, 32'h0, 32'h0, 32'h4);
      check_val("t8_no_done", 32'(cnt_dd() + cnt_id()), 32'h0);
      check_val("t8_nwrites", 32'(wlog_a.size()), 32'h2);
      check_val("t8_w0_a", wlog_a[0], 32'h300);
      check_val("t8_w0_d", 32'(wlog_d[0]), 32'h0D);
      check_val("t8_w1_a", wlog_a[1], 32'h301);
      check_val("t8_w1_d", 32'(wlog_d[1]), 32'h0C);
      check_val("t8_a_c3", tr_a[3], 32'h0);
      check_val("t8_wr_c3", 32'(tr_wr[3]), 32'h0);
      check_val("t8_do_c3", 32'(tr_do[3]), 32'h0);
      check_val("t8_wait_c3", 32'(tr_w[3]), 32'h0);
      check_val("t8_dc_dt_c3", tr_ddt[3], 32'h0);
      check_val("t8_ic_dt_c3", tr_idt[3], 32'h0);
      $display("txn reset mid-store 0x300: %0d bytes written", wlog_a.size());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
